row_scheduler: RTL and testbench
================================

ROW_SCHEDULER -- requirements
Module: row_scheduler

Interface
REQ-001 Parameters:
- ROW_LATENCY, default 1: row-generator read latency in cycles, legal range ≥1.
- FONT_LATENCY, default 1: font ROM read latency in cycles, legal range ≥1.

REQ-002 Ports, one per line:
- clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
- reset_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  screen driver requests one pixel byte.
- pixelAddress_i  in  10  requested byte; [9:7] page, [6:0] column.
- req_ready_o  out  1  scheduler idle; request accepted on req_valid_i & req_ready_o.
- pix_valid_o  out  1  one-cycle pulse; pixelData_o valid.
- pixelData_o  out  8  returned pixel column byte.
- value_i  in  8  live value to display.
- value_o  out  8  frame-stable value driven to all row generators.
- rowMap_i  in  8  four 2-bit row types; bits [2r+1:2r] select screen row r.
- rowMapLoad_i  in  1  stores rowMap_i as the pending map.
- charIndex_o  out  4  character index to the text, binary and hex/dec rows.
- rowPixelAddress_o  out  10  address to the progress row, formed as {2'b00, bottomHalf, column}.
- rowSel_o  out  2  row type of the request in flight.
- textByte_i, binByte_i, hexDecByte_i, progByte_i  in  8 each  row generator outputs.
- fontAddr_o  out  11  font ROM address.
- fontData_i  in  8  font ROM data.

Function
REQ-003 Accepted-address decode: screenRow = [9:8]; bottomHalf = [7]; charIndex = [6:3]; charCol = [2:0].
REQ-004 Row type codes: 0 TEXT, 1 BIN, 2 HEXDEC, 3 PROGRESS; rowSel_o SHALL equal the active-map field for screenRow.
REQ-005 FSM states: IDLE, ROW_WAIT, ROW_READ, FONT_WAIT, FONT_READ, DONE. req_ready_o SHALL be 1 only in IDLE.
REQ-006 Request handling in IDLE:
- An accepted request SHALL register the address and move the FSM to ROW_WAIT.
- req_valid_i outside IDLE SHALL be ignored.
REQ-007 Row wait and read:
- ROW_WAIT SHALL last ROW_LATENCY cycles, then move to ROW_READ.
- ROW_READ SHALL capture the byte selected by rowSel_o.
REQ-008 PROGRESS rows: the captured byte SHALL be loaded directly into pixelData_o and the FSM SHALL move to DONE. pix_valid_o SHALL rise ROW_LATENCY+2 cycles after the accept edge.
REQ-009 Other rows, font address: fontAddr_o = (char-32)*16 + charCol*2 + bottomHalf. A char outside 32..127 SHALL be replaced by 32.
REQ-010 Other rows, font read:
- FONT_WAIT SHALL last FONT_LATENCY cycles.
- FONT_READ SHALL load fontData_i into pixelData_o.
- pix_valid_o SHALL rise ROW_LATENCY+FONT_LATENCY+3 cycles after the accept edge.
REQ-011 DONE SHALL assert pix_valid_o for exactly one cycle, then return to IDLE. pixelData_o SHALL hold until the next load.
REQ-012 charIndex_o, rowPixelAddress_o and rowSel_o SHALL be driven from the registered address and SHALL be stable from the cycle after accept until DONE.
REQ-013 rowMapLoad_i SHALL write the pending map in any state; a later load SHALL overwrite an earlier one.
REQ-014 Frame start is acceptance of pixelAddress_i == 0. At frame start:
- value_o SHALL take value_i.
- The active map SHALL take the pending map.
REQ-015 rowMapLoad_i coincident with frame start SHALL bypass the pending map: rowMap_i SHALL become active for that request.
REQ-016 value_o and the active map SHALL NOT change at any time other than frame start.

Reset
REQ-017 reset_i SHALL asynchronously force:
- state IDLE, req_ready_o=1, pix_valid_o=0, pixelData_o=0;
- value_o=0, fontAddr_o=0, charIndex_o=0, rowPixelAddress_o=0, rowSel_o=0;
- active and pending map = 8'b11_10_01_00.
REQ-018 Reset mid-request SHALL abort the request with no pix_valid_o pulse.

Structure
REQ-019 A shared header SHALL hold the row type codes, the FSM state encodings, the default map 8'b11_10_01_00 and FONT_FIRST_CHAR = 32.
REQ-020 Pending/active map and value snapshot logic SHALL be one sub-module, frame_latch. All remaining logic SHALL live in row_scheduler.

Verification
REQ-021 Text row: default map, request 0x000, textByte_i=0x41, fontData_i=0x7C -> fontAddr_o=0x210; pixelData_o=0x7C with pix_valid_o 5 cycles after accept.
REQ-022 Progress row: request 0x30A, progByte_i=0xF0 -> rowPixelAddress_o=0x00A, rowSel_o=3; pixelData_o=0xF0, pix_valid_o 3 cycles after accept.
REQ-023 Illegal char: row0, request 0x01B (charCol 3, top), textByte_i=0x07 -> fontAddr_o=6. Request 0x09B (bottom) -> fontAddr_o=7.
REQ-024 Snapshot: frame start with value_i=0x10. Change value_i to 0x20 and request 0x12C -> value_o stays 0x10. Next request 0x000 -> value_o=0x20.
REQ-025 Map load: load 8'h03 mid-frame, then request 0x005 -> rowSel_o=0. Request 0x000, then request 0x005 -> rowSel_o=3.
REQ-026 Reset: assert reset_i during FONT_WAIT -> no pix_valid_o, req_ready_o=1, pixelData_o=0. The next request completes normally.

Source files
------------

// File: rtl/row_scheduler_pkg.sv
// Shared definitions for the row scheduler: row type codes, FSM encodings,
// default row map and the font address helper.
package row_scheduler_pkg;

   typedef enum logic [1:0] {
      ROW_TEXT     = 2'd0,
      ROW_BIN      = 2'd1,
      ROW_HEXDEC   = 2'd2,
      ROW_PROGRESS = 2'd3
   } row_type_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ROW_WAIT  = 3'd1,
      ST_ROW_READ  = 3'd2,
      ST_FONT_WAIT = 3'd3,
      ST_FONT_READ = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   localparam logic [7:0] DEFAULT_ROW_MAP = 8'b11_10_01_00;
   localparam logic [7:0] FONT_FIRST_CHAR = 8'd32;
   localparam logic [7:0] FONT_LAST_CHAR  = 8'd127;

   // Glyphs are 16 bytes: two half-height bytes per column, 8 columns per char.
   function automatic logic [10:0] font_addr(input logic [7:0] ch,
                                             input logic [2:0] col,
                                             input logic       bottom);
      logic [7:0] c;
      logic [6:0] off;
      c = ((ch < FONT_FIRST_CHAR) || (ch > FONT_LAST_CHAR)) ? FONT_FIRST_CHAR : ch;
      off = 7'(c - FONT_FIRST_CHAR);
      return {off, col, bottom};
   endfunction

endpackage

// File: rtl/row_scheduler_if.sv
// Pixel request/response handshake between the screen driver and the scheduler.
interface row_scheduler_if;
   logic       req_valid_i;
   logic [9:0] pixelAddress_i;
   logic       req_ready_o;
   logic       pix_valid_o;
   logic [7:0] pixelData_o;

   modport master (
      output req_valid_i,
      output pixelAddress_i,
      input  req_ready_o,
      input  pix_valid_o,
      input  pixelData_o
   );

   modport slave (
      input  req_valid_i,
      input  pixelAddress_i,
      output req_ready_o,
      output pix_valid_o,
      output pixelData_o
   );
endinterface

// File: rtl/row_scheduler_frame_latch.sv
// Pending/active row map and display value snapshot; both only update at
// frame start so a whole frame is drawn from one consistent set of inputs.
module frame_latch
   import row_scheduler_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       i_frame_start,
   input  logic [7:0] value_i,
   input  logic [7:0] rowMap_i,
   input  logic       rowMapLoad_i,
   output logic [7:0] value_o,
   output logic [7:0] o_active_map
);

   logic [7:0] r_pending_map;
   logic [7:0] r_active_map;
   logic [7:0] r_value;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pending_map <= DEFAULT_ROW_MAP;
         r_active_map  <= DEFAULT_ROW_MAP;
         r_value       <= 8'd0;
      end else begin
         if (rowMapLoad_i) begin
            r_pending_map <= rowMap_i;
         end
         // A load landing on the frame-start cycle takes effect immediately.
         if (i_frame_start) begin
            r_active_map <= rowMapLoad_i ? rowMap_i : r_pending_map;
            r_value      <= value_i;
         end
      end
   end

   assign value_o      = r_value;
   assign o_active_map = r_active_map;

endmodule

// File: rtl/row_scheduler.sv
// Serves one pixel byte per request: reads the row generator selected by the
// active row map, then either returns it directly (progress) or via the font ROM.
module row_scheduler
   import row_scheduler_pkg::*;
#(
   parameter int ROW_LATENCY  = 1,
   parameter int FONT_LATENCY = 1
)(
   input  logic              clk_i,
   input  logic              reset_i,
   row_scheduler_if.slave    req_if,
   input  logic [7:0]        value_i,
   output logic [7:0]        value_o,
   input  logic [7:0]        rowMap_i,
   input  logic              rowMapLoad_i,
   output logic [3:0]        charIndex_o,
   output logic [9:0]        rowPixelAddress_o,
   output logic [1:0]        rowSel_o,
   input  logic [7:0]        textByte_i,
   input  logic [7:0]        binByte_i,
   input  logic [7:0]        hexDecByte_i,
   input  logic [7:0]        progByte_i,
   output logic [10:0]       fontAddr_o,
   input  logic [7:0]        fontData_i
);

   localparam logic [15:0] ROW_LAST  = 16'(ROW_LATENCY - 1);
   localparam logic [15:0] FONT_LAST = 16'(FONT_LATENCY - 1);

   state_e      r_state;
   state_e      w_state_next;
   logic [9:0]  r_addr;
   logic [15:0] r_wait_cnt;
   logic [7:0]  r_pix_data;
   logic        r_pix_valid;
   logic [10:0] r_font_addr;

   logic        w_accept;
   logic        w_frame_start;
   logic [7:0]  w_active_map;
   row_type_e   w_row_sel;
   logic [7:0]  w_row_byte;
   logic        w_load_row;
   logic        w_load_font_addr;
   logic        w_load_font_data;

   assign w_accept      = req_if.req_valid_i && (r_state == ST_IDLE);
   assign w_frame_start = w_accept && (req_if.pixelAddress_i == 10'd0);

   frame_latch u_frame_latch (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .i_frame_start (w_frame_start),
      .value_i       (value_i),
      .rowMap_i      (rowMap_i),
      .rowMapLoad_i  (rowMapLoad_i),
      .value_o       (value_o),
      .o_active_map  (w_active_map)
   );

   assign w_row_sel = row_type_e'(w_active_map[{r_addr[9:8], 1'b0} +: 2]);

   always_comb begin
      w_row_byte = textByte_i;
      case (w_row_sel)
         ROW_TEXT:     w_row_byte = textByte_i;
         ROW_BIN:      w_row_byte = binByte_i;
         ROW_HEXDEC:   w_row_byte = hexDecByte_i;
         ROW_PROGRESS: w_row_byte = progByte_i;
         default:      w_row_byte = textByte_i;
      endcase
   end

   always_comb begin
      w_state_next     = r_state;
      w_load_row       = 1'b0;
      w_load_font_addr = 1'b0;
      w_load_font_data = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_ROW_WAIT;
            end
         end
         ST_ROW_WAIT: begin
            if (r_wait_cnt == ROW_LAST) begin
               w_state_next = ST_ROW_READ;
            end
         end
         ST_ROW_READ: begin
            if (w_row_sel == ROW_PROGRESS) begin
               w_load_row   = 1'b1;
               w_state_next = ST_DONE;
            end else begin
               w_load_font_addr = 1'b1;
               w_state_next     = ST_FONT_WAIT;
            end
         end
         ST_FONT_WAIT: begin
            if (r_wait_cnt == FONT_LAST) begin
               w_state_next = ST_FONT_READ;
            end
         end
         ST_FONT_READ: begin
            w_load_font_data = 1'b1;
            w_state_next     = ST_DONE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= 16'd0;
         r_addr      <= 10'd0;
         r_pix_data  <= 8'd0;
         r_pix_valid <= 1'b0;
         r_font_addr <= 11'd0;
      end else begin
         r_state <= w_state_next;
         // Wait counter restarts on every state change, so each wait state
         // counts its own latency from zero.
         if (w_state_next != r_state) begin
            r_wait_cnt <= 16'd0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
         end
         if (w_accept) begin
            r_addr <= req_if.pixelAddress_i;
         end
         if (w_load_row) begin
            r_pix_data <= w_row_byte;
         end else if (w_load_font_data) begin
            r_pix_data <= fontData_i;
         end
         if (w_load_font_addr) begin
            r_font_addr <= font_addr(w_row_byte, r_addr[2:0], r_addr[7]);
         end
         r_pix_valid <= (r_state == ST_DONE);
      end
   end

   assign req_if.req_ready_o = (r_state == ST_IDLE);
   assign req_if.pix_valid_o = r_pix_valid;
   assign req_if.pixelData_o = r_pix_data;

   assign charIndex_o       = r_addr[6:3];
   assign rowPixelAddress_o = {2'b00, r_addr[7], r_addr[6:0]};
   assign rowSel_o          = w_row_sel;
   assign fontAddr_o        = r_font_addr;

endmodule

// File: tb/tb_row_scheduler.sv
// Scoreboard bench for row_scheduler: expected bytes and arrival cycles are
// queued at request time and matched against each pix_valid_o pulse.
module tb_row_scheduler;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [7:0]  value_i = 8'd0;
   logic [7:0]  value_o;
   logic [7:0]  rowMap_i = 8'd0;
   logic        rowMapLoad_i = 1'b0;
   logic [3:0]  charIndex_o;
   logic [9:0]  rowPixelAddress_o;
   logic [1:0]  rowSel_o;
   logic [7:0]  textByte_i = 8'h41;
   logic [7:0]  binByte_i = 8'h55;
   logic [7:0]  hexDecByte_i = 8'h66;
   logic [7:0]  progByte_i = 8'h77;
   logic [10:0] fontAddr_o;
   logic [7:0]  fontData_i = 8'h7C;

   row_scheduler_if bus();

   row_scheduler #(.ROW_LATENCY(1), .FONT_LATENCY(1)) dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .req_if            (bus.slave),
      .value_i           (value_i),
      .value_o           (value_o),
      .rowMap_i          (rowMap_i),
      .rowMapLoad_i      (rowMapLoad_i),
      .charIndex_o       (charIndex_o),
      .rowPixelAddress_o (rowPixelAddress_o),
      .rowSel_o          (rowSel_o),
      .textByte_i        (textByte_i),
      .binByte_i         (binByte_i),
      .hexDecByte_i      (hexDecByte_i),
      .progByte_i        (progByte_i),
      .fontAddr_o        (fontAddr_o),
      .fontData_i        (fontData_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;
   int ncyc = 0;
   int pulses = 0;

   string      tag_q[$];
   logic [7:0] exp_q[$];
   int         cyc_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) ncyc <= ncyc + 1;

   always @(negedge clk_i) begin
      if (!reset_i && bus.pix_valid_o) begin
         pulses++;
         if (exp_q.size() == 0) begin
            chk("pix_unexpected", 32'd1, 32'd0);
         end else begin
            string      t;
            logic [7:0] e;
            int         c;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            $display("txn %s data=0x%02h cyc=%0d", t, bus.pixelData_o, ncyc);
            chk({t, "_data"}, 32'(bus.pixelData_o), 32'(e));
            chk({t, "_cycle"}, 32'(ncyc), 32'(c));
         end
      end
   end

   // Called at a falling edge; holds the request for exactly one rising edge.
   task automatic send(input string tag, input logic [9:0] a, input logic [7:0] exp,
                       input int lat, input logic ld, input logic [7:0] map);
      int n = 0;
      while (!bus.req_ready_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
      bus.req_valid_i    = 1'b1;
      bus.pixelAddress_i = a;
      rowMapLoad_i       = ld;
      rowMap_i           = map;
      tag_q.push_back(tag);
      exp_q.push_back(exp);
      cyc_q.push_back(ncyc + 1 + lat);
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      rowMapLoad_i    = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) begin
         chk({tag, "_done_timeout"}, 32'd0, 32'd1);
         tag_q.delete();
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   task automatic load_map(input logic [7:0] map);
      rowMapLoad_i = 1'b1;
      rowMap_i     = map;
      @(negedge clk_i);
      rowMapLoad_i = 1'b0;
   endtask

   initial begin
      bus.req_valid_i    = 1'b0;
      bus.pixelAddress_i = 10'd0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
      chk("rst_pix_valid", 32'(bus.pix_valid_o), 32'd0);
      chk("rst_pix_data", 32'(bus.pixelData_o), 32'd0);
      chk("rst_value", 32'(value_o), 32'd0);
      chk("rst_font_addr", 32'(fontAddr_o), 32'd0);
      chk("rst_char_index", 32'(charIndex_o), 32'd0);
      chk("rst_row_pix_addr", 32'(rowPixelAddress_o), 32'd0);
      chk("rst_row_sel", 32'(rowSel_o), 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);

      // Text row, frame start with value 0x10
      value_i = 8'h10;
      send("text", 10'h000, 8'h7C, 5, 1'b0, 8'h00);
      wait_done("text");
      chk("text_font_addr", 32'(fontAddr_o), 32'h210);
      chk("text_row_sel", 32'(rowSel_o), 32'd0);
      chk("text_value", 32'(value_o), 32'h10);
      @(negedge clk_i);
      chk("text_data_hold", 32'(bus.pixelData_o), 32'h7C);

      // Progress row; value_i change must not reach value_o mid-frame
      value_i    = 8'h20;
      progByte_i = 8'hF0;
      send("prog", 10'h30A, 8'hF0, 3, 1'b0, 8'h00);
      wait_done("prog");
      chk("prog_row_pix_addr", 32'(rowPixelAddress_o), 32'h00A);
      chk("prog_row_sel", 32'(rowSel_o), 32'd3);

      // Illegal and boundary characters
      textByte_i = 8'h07;
      fontData_i = 8'h11;
      send("illegal_top", 10'h01B, 8'h11, 5, 1'b0, 8'h00);
      wait_done("illegal_top");
      chk("illegal_top_font_addr", 32'(fontAddr_o), 32'd6);
      chk("illegal_top_char_index", 32'(charIndex_o), 32'd3);
      send("illegal_bot", 10'h09B, 8'h11, 5, 1'b0, 8'h00);
      wait_done("illegal_bot");
      chk("illegal_bot_font_addr", 32'(fontAddr_o), 32'd7);
      textByte_i = 8'h80;
      send("char128", 10'h02A, 8'h11, 5, 1'b0, 8'h00);
      wait_done("char128");
      chk("char128_font_addr", 32'(fontAddr_o), 32'd4);
      textByte_i = 8'h7F;
      send("char127", 10'h001, 8'h11, 5, 1'b0, 8'h00);
      wait_done("char127");
      chk("char127_font_addr", 32'(fontAddr_o), 32'd1522);

      // Snapshot: bin row mid-frame, then new frame
      fontData_i = 8'h3C;
      send("snap_mid", 10'h12C, 8'h3C, 5, 1'b0, 8'h00);
      wait_done("snap_mid");
      chk("snap_mid_value", 32'(value_o), 32'h10);
      chk("snap_mid_row_sel", 32'(rowSel_o), 32'd1);
      chk("snap_mid_font_addr", 32'(fontAddr_o), 32'h358);
      textByte_i = 8'h41;
      send("snap_frame", 10'h000, 8'h3C, 5, 1'b0, 8'h00);
      wait_done("snap_frame");
      chk("snap_frame_value", 32'(value_o), 32'h20);

      // Map load: pending until frame start
      load_map(8'h03);
      send("map_pend", 10'h005, 8'h3C, 5, 1'b0, 8'h00);
      wait_done("map_pend");
      chk("map_pend_row_sel", 32'(rowSel_o), 32'd0);
      send("map_frame", 10'h000, 8'hF0, 3, 1'b0, 8'h00);
      wait_done("map_frame");
      chk("map_frame_row_sel", 32'(rowSel_o), 32'd3);
      send("map_active", 10'h005, 8'hF0, 3, 1'b0, 8'h00);
      wait_done("map_active");
      chk("map_active_row_sel", 32'(rowSel_o), 32'd3);

      // Later load overwrites earlier one
      load_map(8'h01);
      load_map(8'h02);
      hexDecByte_i = 8'h41;
      fontData_i   = 8'h5A;
      send("map_over", 10'h000, 8'h5A, 5, 1'b0, 8'h00);
      wait_done("map_over");
      chk("map_over_row_sel", 32'(rowSel_o), 32'd2);
      chk("map_over_font_addr", 32'(fontAddr_o), 32'h210);

      // Load coincident with frame start bypasses pending map
      send("map_bypass", 10'h000, 8'h5A, 5, 1'b1, 8'hE4);
      wait_done("map_bypass");
      chk("map_bypass_row_sel", 32'(rowSel_o), 32'd0);

      // Reset during FONT_WAIT aborts the request
      bus.req_valid_i    = 1'b1;
      bus.pixelAddress_i = 10'h045;
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      pulses  = 0;
      reset_i = 1'b1;
      #1;
      chk("abort_ready", 32'(bus.req_ready_o), 32'd1);
      chk("abort_pix_data", 32'(bus.pixelData_o), 32'd0);
      chk("abort_pix_valid", 32'(bus.pix_valid_o), 32'd0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      repeat (10) @(negedge clk_i);
      chk("abort_no_pulse", 32'(pulses), 32'd0);
      value_i    = 8'h99;
      fontData_i = 8'h7C;
      send("after_rst", 10'h000, 8'h7C, 5, 1'b0, 8'h00);
      wait_done("after_rst");
      chk("after_rst_value", 32'(value_o), 32'h99);
      chk("after_rst_font_addr", 32'(fontAddr_o), 32'h210);

      repeat (3) @(negedge clk_i);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
